free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter DEPTH, default `ROB_SZ, meaning number of free-list entries, a power of two.
REQ-002 SHALL have parameter N, default `N, meaning superscalar width.
REQ-003 SHALL have parameter BASE, default 32, meaning the lowest physical register index held at reset.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rd_num  input  $clog2(N+1)  number of registers dispatch allocates this cycle.
REQ-007 SHALL have port wr_reg  input  N x PHYS_REG_IDX  registers freed by retire (ROB t_old), oldest at [0].
REQ-008 SHALL have port wr_num  input  $clog2(N+1)  number of valid wr_reg lanes, in the range 0..N.
REQ-009 SHALL have port br_en  input  1  mispredict recovery strobe.
REQ-010 SHALL have port br_head  input  $clog2(DEPTH)+1  checkpointed head pointer, including the wrap bit.
REQ-011 SHALL have port rd_reg  output  N x PHYS_REG_IDX  next free registers, oldest at [0].
REQ-012 SHALL have port num_avail  output  $clog2(N+1)  allocatable count, min(N, available).
REQ-013 SHALL have port out_head  output  $clog2(DEPTH)+1  current head, for branch checkpointing.

Function
REQ-014 SHALL implement a circular buffer with head and tail pointers of $clog2(DEPTH)+1 bits.
- The extra MSB is the wrap bit.
- count = tail - head (modulo 2^(log+1)).
- Full when count == DEPTH; empty when count == 0.
REQ-015 SHALL select effective head eh = br_en ? br_head : head; eff_count = tail - eh.
REQ-016 SHALL drive rd_reg[i] = entries[(eh+i) mod DEPTH] combinationally for all i < N.
- Lanes with i >= num_avail are don't-care.
REQ-017 SHALL drive num_avail = min(N, eff_count) combinationally; zero latency.
REQ-018 SHALL on posedge set head <= eh + rd_num.
- rd_num > num_avail is illegal and SHALL fire a simulation assertion.
REQ-019 SHALL on posedge write wr_reg[j] to entries[(tail+j) mod DEPTH] for each j < wr_num, and set tail <= tail + wr_num.
REQ-020 SHALL make frees take effect regardless of br_en.
- Retired registers are never squashed.
REQ-021 SHALL treat a free that would make count exceed DEPTH as illegal and fire an assertion.
- State is then undefined.
REQ-022 SHALL let allocate and free in the same cycle both apply.
- Without the bypass feature, a freed register is allocatable no earlier than the next cycle.
REQ-023 SHALL wrap both pointers modulo 2^(log+1).
- Entry addressing uses only the low $clog2(DEPTH) bits.
REQ-024 SHALL drive out_head = head (registered value).
REQ-025 SHALL keep entries holding unique indices across wrap-around with no loss.

Reset
REQ-026 SHALL on reset asynchronously load entries[i] = BASE + i for all i.
REQ-027 SHALL on reset set head = 0 and tail = DEPTH (wrap bit 1, low bits 0), i.e. full.
REQ-028 SHALL after reset drive rd_reg = BASE..BASE+N-1, num_avail = N, out_head = 0.
REQ-029 SHALL, when reset is asserted mid-operation, override any in-flight rd_num, wr_num or br_en immediately.
- No partial update survives.

Configuration
REQ-030 SHALL support macro FREE_LIST_BYPASS_EN.
- When it is defined, num_avail = min(N, eff_count + wr_num).
- rd_reg[i] for i >= eff_count SHALL forward wr_reg[i - eff_count].
- Bypassed registers SHALL still be written to the buffer and consumed via head advance, keeping pointers consistent.
- When it is undefined, behaviour is exactly REQ-016/017 and wr_reg does not affect outputs combinationally.

Verification (N=3, DEPTH=32, BASE=32)
REQ-031 Reset, no activity -> rd_reg = {32,33,34}, num_avail = 3, out_head = 0.
REQ-032 rd_num = 3 for 10 cycles -> out_head = 30, rd_reg[0..1] = {62,63}, num_avail = 2; rd_num = 2 -> num_avail = 0.
REQ-033 From empty, wr_num = 3 with wr_reg = {5,6,7} -> next cycle rd_reg = {5,6,7}, num_avail = 3, tail wraps to 35 (low bits 3).
REQ-034 Checkpoint out_head = 3, allocate 6, then br_en = 1 with br_head = 3 and rd_num = 1 -> rd_reg[0] = 35 that cycle, out_head = 4 next.
REQ-035 FREE_LIST_BYPASS_EN defined, empty list, wr_num = 2 with {9,10} -> same cycle num_avail = 2, rd_reg[0..1] = {9,10}; rd_num = 2 -> count 0 next.
REQ-036 Async reset pulsed between clock edges during rd_num = 3 -> outputs return to REQ-031 values before the next posedge.

Source files
------------

// File: rtl/free_list.sv
// Circular free list of physical register indices with branch-recovery head restore.
// Optional FREE_LIST_BYPASS_EN forwards same-cycle frees to the allocation outputs.
`ifndef ROB_SZ
`define ROB_SZ 32
`endif
`ifndef N
`define N 3
`endif

module free_list #(
    parameter int unsigned DEPTH  = `ROB_SZ,
    parameter int unsigned N      = `N,
    parameter int unsigned BASE   = 32,
    parameter int unsigned PREG_W = $clog2(BASE + DEPTH),
    localparam int unsigned LOG   = $clog2(DEPTH),
    localparam int unsigned PW    = LOG + 1,
    localparam int unsigned CW    = $clog2(N + 1),
    localparam int unsigned LW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [CW-1:0]                rd_num,
    input  logic [N-1:0][PREG_W-1:0]     wr_reg,
    input  logic [CW-1:0]                wr_num,
    input  logic                         br_en,
    input  logic [PW-1:0]                br_head,
    output logic [N-1:0][PREG_W-1:0]     rd_reg,
    output logic [CW-1:0]                num_avail,
    output logic [PW-1:0]                out_head
);

    logic [PREG_W-1:0] entries [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [PW-1:0]     eh;
    logic [PW-1:0]     eff_count;
    logic [PW:0]       cnt_ext;
    logic [PW-1:0]     idx;
    logic [PW-1:0]     lane;

    assign eh        = br_en ? br_head : head;
    assign eff_count = tail - eh;
    assign out_head  = head;

`ifdef FREE_LIST_BYPASS_EN
    assign cnt_ext = {1'b0, eff_count} + (PW+1)'(wr_num);
`else
    assign cnt_ext = {1'b0, eff_count};
`endif

    assign num_avail = (cnt_ext >= (PW+1)'(N)) ? CW'(N) : cnt_ext[CW-1:0];

    always_comb begin
        idx    = '0;
        lane   = '0;
        rd_reg = '0;
        for (int i = 0; i < N; i++) begin
            idx       = eh + PW'(i);
            rd_reg[i] = entries[idx[LOG-1:0]];
`ifdef FREE_LIST_BYPASS_EN
            // Lanes past the buffered count come straight from this cycle's frees.
            if (PW'(i) >= eff_count) begin
                lane      = PW'(i) - eff_count;
                rd_reg[i] = wr_reg[lane[LW-1:0]];
            end
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= PW'(DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= PREG_W'(BASE + i);
            end
        end else begin
            head <= eh + PW'(rd_num);
            tail <= tail + PW'(wr_num);
            for (int j = 0; j < N; j++) begin
                if (CW'(j) < wr_num) begin
                    entries[LOG'(tail + PW'(j))] <= wr_reg[j];
                end
            end
        end
    end

`ifndef SYNTHESIS
    a_rd_legal: assert property (@(posedge clock) disable iff (reset) rd_num <= num_avail)
        else $error("free_list: rd_num exceeds num_avail");
    a_wr_lanes: assert property (@(posedge clock) disable iff (reset) wr_num <= CW'(N))
        else $error("free_list: wr_num exceeds N");
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        ({1'b0, eff_count} + (PW+1)'(wr_num)) <= ((PW+1)'(DEPTH) + (PW+1)'(rd_num)))
        else $error("free_list: free overflows the list");
`endif

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: queue-based reference model feeding a scoreboard.
module tb_free_list;

    localparam int N     = 3;
    localparam int DEPTH = 32;
    localparam int BASE  = 32;

    logic            clock = 1'b0;
    logic            reset;
    logic [1:0]      rd_num;
    logic [2:0][5:0] wr_reg;
    logic [1:0]      wr_num;
    logic            br_en;
    logic [5:0]      br_head;
    logic [2:0][5:0] rd_reg;
    logic [1:0]      num_avail;
    logic [5:0]      out_head;

    always #5 clock = ~clock;

    free_list #(
        .DEPTH (DEPTH),
        .N     (N),
        .BASE  (BASE)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rd_num    (rd_num),
        .wr_reg    (wr_reg),
        .wr_num    (wr_num),
        .br_en     (br_en),
        .br_head   (br_head),
        .rd_reg    (rd_reg),
        .num_avail (num_avail),
        .out_head  (out_head)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: ordered free regs, allocation history, regs currently in use.
    int fl[$];
    int hist[$];
    int inuse[$];
    int hd;
    int cp_len;
    int cp_head;

    // Scoreboard: tag, what to observe (0 head, 1 avail, 2+i lane i), expected value.
    string sb_tag[$];
    int    sb_kind[$];
    int    sb_exp[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        checks++;
        if (got !== 32'(exp)) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int kind, input int exp);
        sb_tag.push_back(tag);
        sb_kind.push_back(kind);
        sb_exp.push_back(exp);
    endtask

    task automatic sb_drain();
        string       tag;
        int          kind;
        int          exp;
        logic [31:0] got;
        while (sb_tag.size() > 0) begin
            tag  = sb_tag.pop_front();
            kind = sb_kind.pop_front();
            exp  = sb_exp.pop_front();
            if (kind == 0)      got = 32'(out_head);
            else if (kind == 1) got = 32'(num_avail);
            else                got = 32'(rd_reg[kind-2]);
            check_eq(tag, got, exp);
        end
    endtask

    task automatic model_reset();
        fl.delete();
        hist.delete();
        inuse.delete();
        for (int i = 0; i < DEPTH; i++) fl.push_back(BASE + i);
        hd = 0;
    endtask

    task automatic push_idle_expect();
        sb_push("out_head", 0, hd);
        sb_push("num_avail", 1, N);
        for (int i = 0; i < N; i++) sb_push($sformatf("rd_reg%0d", i), 2 + i, fl[i]);
    endtask

    // One cycle: drive, check combinational outputs, clock, advance the model.
    task automatic step(input int rd, input int wn, input int w0, input int w1, input int w2,
                        input bit br, input int bh);
        int eff[$];
        int wl[3];
        int navail;
        int r;
        wl      = '{w0, w1, w2};
        rd_num  = 2'(rd);
        wr_num  = 2'(wn);
        wr_reg[0] = 6'(w0);
        wr_reg[1] = 6'(w1);
        wr_reg[2] = 6'(w2);
        br_en   = br;
        br_head = 6'(bh);
        if (br) for (int k = cp_len; k < hist.size(); k++) eff.push_back(hist[k]);
        foreach (fl[k]) eff.push_back(fl[k]);
`ifdef FREE_LIST_BYPASS_EN
        for (int j = 0; j < wn; j++) eff.push_back(wl[j]);
`endif
        navail = (eff.size() > N) ? N : eff.size();
        sb_push("out_head", 0, hd);
        sb_push("num_avail", 1, navail);
        for (int i = 0; i < navail; i++) sb_push($sformatf("rd_reg%0d", i), 2 + i, eff[i]);
        #2;
        sb_drain();
        @(posedge clock);
        if (br) begin
            while (hist.size() > cp_len) begin
                void'(hist.pop_back());
                void'(inuse.pop_back());
            end
        end
        for (int k = 0; k < rd; k++) begin
            r = eff.pop_front();
            hist.push_back(r);
            inuse.push_back(r);
        end
`ifndef FREE_LIST_BYPASS_EN
        for (int j = 0; j < wn; j++) eff.push_back(wl[j]);
`endif
        fl = eff;
        hd = ((br ? bh : hd) + rd) % 64;
        #1;
    endtask

    task automatic free_step(input int rd, input int wn);
        int w[3];
        w = '{0, 0, 0};
        for (int j = 0; j < wn; j++) w[j] = inuse.pop_front();
        step(rd, wn, w[0], w[1], w[2], 1'b0, 0);
    endtask

    initial begin
        int wn;
        int rd;
        int lim;
        reset   = 1'b1;
        rd_num  = '0;
        wr_num  = '0;
        wr_reg  = '0;
        br_en   = 1'b0;
        br_head = '0;
        model_reset();
        #23 reset = 1'b0;
        @(posedge clock);
        #1;

        // Reset state, then drain the list three at a time.
        step(0, 0, 0, 0, 0, 1'b0, 0);
        repeat (10) step(3, 0, 0, 0, 0, 1'b0, 0);
        step(2, 0, 0, 0, 0, 1'b0, 0);
        step(0, 0, 0, 0, 0, 1'b0, 0);

        // Free into an empty list; visible next cycle (same cycle with bypass).
        step(0, 3, 5, 6, 7, 1'b0, 0);
        step(0, 0, 0, 0, 0, 1'b0, 0);
        step(3, 0, 0, 0, 0, 1'b0, 0);
`ifdef FREE_LIST_BYPASS_EN
        step(2, 2, 9, 10, 0, 1'b0, 0);
        step(0, 0, 0, 0, 0, 1'b0, 0);
`endif

        // Checkpoint, allocate six, recover with a one-register allocate.
        free_step(0, 3);
        free_step(0, 3);
        cp_len  = hist.size();
        cp_head = hd;
        step(3, 0, 0, 0, 0, 1'b0, 0);
        step(3, 0, 0, 0, 0, 1'b0, 0);
        step(1, 0, 0, 0, 0, 1'b1, cp_head);
        step(0, 0, 0, 0, 0, 1'b0, 0);

        // Recovery coinciding with frees and allocation.
        free_step(0, 3);
        cp_len  = hist.size();
        cp_head = hd;
        step(2, 0, 0, 0, 0, 1'b0, 0);
        begin
            int a;
            int b;
            a = inuse.pop_front();
            b = inuse.pop_front();
            step(1, 2, a, b, 0, 1'b1, cp_head);
        end
        step(0, 0, 0, 0, 0, 1'b0, 0);

        // Random legal traffic with concurrent allocate and free across wrap-around.
        repeat (300) begin
            wn = $urandom_range(0, 3);
            if (wn > DEPTH - fl.size()) wn = DEPTH - fl.size();
            if (wn > inuse.size()) wn = inuse.size();
            lim = fl.size();
`ifdef FREE_LIST_BYPASS_EN
            lim = lim + wn;
`endif
            if (lim > N) lim = N;
            rd = $urandom_range(0, lim);
            free_step(rd, wn);
        end

        // Asynchronous reset pulsed between edges while allocating.
        rd_num = 2'd3;
        wr_num = '0;
        br_en  = 1'b0;
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        model_reset();
        push_idle_expect();
        #1;
        sb_drain();
        rd_num = '0;
        @(posedge clock);
        #1;
        step(0, 0, 0, 0, 0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
